apb3_decoder_tmo: RTL
=====================

# apb3_decoder_tmo

Parametrised APB3 interconnect: one upstream APB3 master port fanned out to NS downstream APB3 slave ports by address decode, with decode-error completion for unmapped addresses and a per-transfer timeout watchdog that completes hung transfers with PSLVERR. It sits between the CPU-side APB bridge and the block register slaves of the video pipeline. It also keeps sticky error status for firmware debug.

## Interface
- DW, 32, data width.
- AW, 32, address width.
- NS, 4, number of slave ports (1..16); IW = max(1, $clog2(NS)).
- SLV_AW, 12, byte-address bits per slave window (4 KiB).
- BASE, 32'h4000_0000, region base; bits above SLV_AW+IW must match BASE.
- TMO, 255, wait-state limit per transfer; 0 disables timeout. CW = $clog2(TMO+2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- m_psel, m_penable, m_pwrite  in  1  master request.
- m_paddr  in  AW  master address.
- m_pwdata  in  DW  master write data.
- m_prdata  out  DW  read data to master.
- m_pready, m_pslverr  out  1  completion and error to master.
- s_psel  out  NS  one-hot slave select.
- s_penable, s_pwrite  out  1  broadcast.
- s_paddr  out  AW  broadcast, unmodified.
- s_pwdata  out  DW  broadcast.
- s_prdata  in  NS*DW  slave i at [i*DW +: DW].
- s_pready, s_pslverr  in  NS  per-slave response.
- err_cnt  out  16  saturating count of error completions.
- tmo_flag  out  1  sticky timeout seen.
- tmo_idx  out  IW  slave index of last timeout.
- err_clr  in  1  one-cycle pulse: clears err_cnt, tmo_flag, tmo_idx.

## Operation
- Decode: hit = (m_paddr[AW-1:SLV_AW+IW] == BASE[AW-1:SLV_AW+IW]) and idx < NS; idx = m_paddr[SLV_AW +: IW]. Non-power-of-2 NS leaves idx >= NS unmapped.
- Request path combinational: s_psel[i] = m_psel & hit & (idx==i) & !abort; s_penable = m_penable; other request signals pass through.
- FSM, registered, state from master signals: IDLE (m_psel=0), SETUP (m_psel & !m_penable), ACCESS (m_psel & m_penable). Transitions: IDLE->SETUP; SETUP->ACCESS; ACCESS->ACCESS while m_pready=0; ACCESS->SETUP or IDLE after completion, following the master. m_psel dropped in any state -> IDLE, counter cleared.
- Response, ACCESS only:
  - hit and slave not timed out: m_pready/m_pslverr/m_prdata = selected slave's signals.
  - miss: m_pready=1, m_pslverr=1, m_prdata=0 on first ACCESS cycle (zero wait).
  - timeout: see below. Outside ACCESS, m_pready=0, m_pslverr=0, m_prdata=0.
- Timeout: counter cnt (CW bits) is 0 on entering ACCESS. It increments each ACCESS cycle with selected s_pready=0 and cnt<TMO. In an ACCESS cycle with cnt==TMO, TMO!=0 and s_pready=0, abort=1: s_psel forced 0 that cycle, m_pready=1, m_pslverr=1, m_prdata=0. tmo_flag<=1 and tmo_idx<=idx.
- err_cnt increments on every completion with m_pslverr=1 (decode, timeout, or slave error); saturates at 16'hFFFF. err_clr has priority over a same-cycle increment or timeout update.
- Reset: FSM=IDLE, cnt=0, err_cnt=0, tmo_flag=0, tmo_idx=0; all outputs 0 while rst high. Reset mid-transfer abandons the transfer silently with no error count.

## Timing
- Request and response paths: zero latency, combinational; status registers update on the clk edge after the completing cycle.
- Minimum transfer: 2 cycles (SETUP + 1 ACCESS) for a zero-wait slave or a miss.
- Hung slave: transfer completes on ACCESS cycle TMO+1; total TMO+2 cycles including SETUP.
- Slave asserting ready on the same cycle as cnt==TMO: the slave response wins and no timeout is recorded.
- Back-to-back transfers (ACCESS -> SETUP without IDLE): cnt clears, idx re-decodes from the new address.

## Test plan
- Write 0x4000_1004 (idx 1), slave 1 zero-wait -> s_psel=4'b0010 in SETUP and ACCESS; m_pready=1 on cycle 2; err_cnt=0.
- Read 0x4000_2008, slave 2 returns 0xDEAD_BEEF after 3 wait states -> m_prdata=0xDEAD_BEEF with m_pready on ACCESS cycle 4; no error.
- Read 0x5000_0000 (miss) -> no s_psel asserted; m_pready=1, m_pslverr=1, m_prdata=0 on first ACCESS cycle; err_cnt=1.
- TMO=255, slave 3 never ready -> completion with m_pslverr=1 on ACCESS cycle 256; tmo_flag=1, tmo_idx=3, err_cnt incremented. Repeat with ready at ACCESS cycle 256 -> normal completion, no flag.
- Assert rst mid-ACCESS, then send a fresh transfer -> all outputs 0 during reset; err_cnt unchanged at 0; next transfer normal.
- Pulse err_clr on the same cycle as a timeout completion -> err_cnt=0, tmo_flag=0 afterwards; 65 536 forced errors -> err_cnt holds 0xFFFF.

Source files
------------

// File: rtl/apb3_decoder_tmo.sv
// APB3 one-to-NS address decoder with decode-error completion,
// per-transfer wait-state watchdog and sticky error status.
module apb3_decoder_tmo #(
  parameter int              DW     = 32,
  parameter int              AW     = 32,
  parameter int              NS     = 4,
  parameter int              SLV_AW = 12,
  parameter logic [AW-1:0]   BASE   = 32'h4000_0000,
  parameter int              TMO    = 255,
  localparam int             IW     = (NS > 1) ? $clog2(NS) : 1,
  localparam int             CW     = $clog2(TMO + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_psel,
  input  logic             m_penable,
  input  logic             m_pwrite,
  input  logic [AW-1:0]    m_paddr,
  input  logic [DW-1:0]    m_pwdata,
  output logic [DW-1:0]    m_prdata,
  output logic             m_pready,
  output logic             m_pslverr,
  output logic [NS-1:0]    s_psel,
  output logic             s_penable,
  output logic             s_pwrite,
  output logic [AW-1:0]    s_paddr,
  output logic [DW-1:0]    s_pwdata,
  input  logic [NS*DW-1:0] s_prdata,
  input  logic [NS-1:0]    s_pready,
  input  logic [NS-1:0]    s_pslverr,
  output logic [15:0]      err_cnt,
  output logic             tmo_flag,
  output logic [IW-1:0]    tmo_idx,
  input  logic             err_clr
);

  localparam int            TB     = SLV_AW + IW;
  localparam logic [CW-1:0] TMO_C  = CW'(TMO);
  localparam bit            TMO_EN = (TMO != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic          tmo_flag_q, tmo_flag_d;
  logic [IW-1:0] tmo_idx_q, tmo_idx_d;

  logic [IW-1:0] idx;
  logic          tag_ok;
  logic          idx_ok;
  logic          hit;
  logic          access;
  logic          abort;
  logic          complete;
  logic          sel_ready;
  logic          sel_err;
  logic [DW-1:0] sel_rdata;
  logic [CW-1:0] cnt_cur;

  assign tag_ok = (m_paddr[AW-1:TB] == BASE[AW-1:TB]);
  assign idx    = m_paddr[SLV_AW +: IW];

  // Window index beyond NS (non power-of-2 NS) leaves idx_ok low.
  always_comb begin
    idx_ok    = 1'b0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (idx == IW'(i)) begin
        idx_ok    = 1'b1;
        sel_ready = s_pready[i];
        sel_err   = s_pslverr[i];
        sel_rdata = s_prdata[i*DW +: DW];
      end
    end
  end

  assign hit    = tag_ok & idx_ok;
  assign access = ~rst & m_psel & m_penable;

  // The wait counter only carries over between consecutive ACCESS cycles.
  assign cnt_cur = (state_q == ACCESS) ? cnt_q : '0;

  assign abort = access & hit & TMO_EN &
                 (cnt_cur == TMO_C) & ~sel_ready;

  always_comb begin
    s_psel    = '0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    if (!rst) begin
      s_penable = m_penable;
      s_pwrite  = m_pwrite;
      s_paddr   = m_paddr;
      s_pwdata  = m_pwdata;
      for (int i = 0; i < NS; i++) begin
        s_psel[i] = m_psel & hit & (idx == IW'(i)) & ~abort;
      end
    end
  end

  always_comb begin
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    m_prdata  = '0;
    if (access) begin
      if (!hit || abort) begin
        m_pready  = 1'b1;
        m_pslverr = 1'b1;
      end else begin
        m_pready  = sel_ready;
        m_pslverr = sel_err;
        m_prdata  = sel_rdata;
      end
    end
  end

  assign complete = access & m_pready;

  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    if (!m_psel) begin
      state_d = IDLE;
    end else if (!m_penable) begin
      state_d = SETUP;
    end else begin
      state_d = ACCESS;
    end
    if (access && !complete && (cnt_cur < TMO_C)) begin
      cnt_d = cnt_cur + 1'b1;
    end
  end

  // Clear wins over a same-cycle error count or timeout capture.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    tmo_flag_d = tmo_flag_q;
    tmo_idx_d  = tmo_idx_q;
    if (err_clr) begin
      err_cnt_d  = '0;
      tmo_flag_d = 1'b0;
      tmo_idx_d  = '0;
    end else begin
      if (complete && m_pslverr && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      if (abort) begin
        tmo_flag_d = 1'b1;
        tmo_idx_d  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
      tmo_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_idx_q  <= tmo_idx_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign tmo_flag = tmo_flag_q;
  assign tmo_idx  = tmo_idx_q;

endmodule
